// File: rtl/ram8_fifo_ctrl.sv
// ram8_fifo_ctrl: runs an 8-entry RAM8 word store as a FIFO with a push/pop handshake.
// Every accepted operation takes two cycles. The first cycle registers the RAM strobe.
// The second cycle completes the operation. For a read, that completion is the
// registered capture of ram_q.
module ram8_fifo_ctrl #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 3,
    parameter int unsigned DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    output logic          push_ready,
    input  logic          pop,
    output logic          pop_ready,
    output logic          pop_valid,
    output logic [DW-1:0] pop_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_d,
    output logic          ram_w,
    output logic          ram_r,
    input  logic [DW-1:0] ram_q
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_d_q, ram_d_d;
    logic          ram_w_q, ram_w_d;
    logic          ram_r_q, ram_r_d;
    logic          pop_valid_q, pop_valid_d;
    logic [DW-1:0] pop_data_q, pop_data_d;

    // Status flags come straight from the registered occupancy
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

    // Handshake: only IDLE accepts. A push that can be accepted blocks a pop.
    assign push_ready = (state_q == S_IDLE) && !full;
    assign pop_ready  = (state_q == S_IDLE) && !empty && !(push && !full);

    assign ram_addr  = ram_addr_q;
    assign ram_d     = ram_d_q;
    assign ram_w     = ram_w_q;
    assign ram_r     = ram_r_q;
    assign pop_valid = pop_valid_q;
    assign pop_data  = pop_data_q;

    // Next-state and next-output decode
    always_comb begin
        state_d     = state_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        ram_addr_d  = ram_addr_q;
        ram_d_d     = ram_d_q;
        ram_w_d     = 1'b0;
        ram_r_d     = 1'b0;
        pop_valid_d = 1'b0;
        pop_data_d  = pop_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (push && push_ready) begin
                    ram_addr_d = wptr_q;
                    ram_d_d    = push_data;
                    ram_w_d    = 1'b1;
                    wptr_d     = wptr_q + AW'(1);
                    count_d    = count_q + CW'(1);
                    state_d    = S_WRITE;
                end else if (pop && pop_ready) begin
                    ram_addr_d = rptr_q;
                    ram_r_d    = 1'b1;
                    rptr_d     = rptr_q + AW'(1);
                    count_d    = count_q - CW'(1);
                    state_d    = S_READ;
                end
            end
            S_WRITE: begin
                state_d = S_IDLE;
            end
            S_READ: begin
                pop_data_d  = ram_q;
                pop_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards queue contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            ram_addr_q  <= '0;
            ram_d_q     <= '0;
            ram_w_q     <= 1'b0;
            ram_r_q     <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            ram_addr_q  <= ram_addr_d;
            ram_d_q     <= ram_d_d;
            ram_w_q     <= ram_w_d;
            ram_r_q     <= ram_r_d;
            pop_valid_q <= pop_valid_d;
            pop_data_q  <= pop_data_d;
        end
    end

endmodule

// File: tb/tb_ram8_fifo_ctrl.sv
// tb_ram8_fifo_ctrl: FIFO controller bench. A behavioural RAM8 serves the controller.
// A queue-based reference model tracks the expected FIFO state.
module tb_ram8_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        push;
    logic [15:0] push_data;
    logic        push_ready;
    logic        pop;
    logic        pop_ready;
    logic        pop_valid;
    logic [15:0] pop_data;
    logic        full;
    logic        empty;
    logic [3:0]  count;
    logic [2:0]  ram_addr;
    logic [15:0] ram_d;
    logic        ram_w;
    logic        ram_r;
    logic [15:0] ram_q;

    int n_vec = 0;
    int n_err = 0;

    ram8_fifo_ctrl #(.DW(16), .AW(3), .DEPTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_data  (push_data),
        .push_ready (push_ready),
        .pop        (pop),
        .pop_ready  (pop_ready),
        .pop_valid  (pop_valid),
        .pop_data   (pop_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ram_addr   (ram_addr),
        .ram_d      (ram_d),
        .ram_w      (ram_w),
        .ram_r      (ram_r),
        .ram_q      (ram_q)
    );

    always #5 clk = ~clk;

    // Behavioural RAM8 word store
    logic [15:0] mem [8];
    always @(posedge clk) if (ram_w) mem[ram_addr] <= ram_d;
    assign ram_q = mem[ram_addr];

    // Reference model state
    logic [15:0] mq[$];
    int          wr_idx  = 0;
    int          rd_idx  = 0;
    int          busy    = 0;   // 0 idle, 1 write in flight, 2 read in flight
    logic [15:0] pend    = '0;
    logic [15:0] last_pd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        wr_idx  = 0;
        rd_idx  = 0;
        busy    = 0;
        last_pd = '0;
    endtask

    // One clock of stimulus with full comparison against the model
    task automatic step(input logic p, input logic c, input logic [15:0] d);
        logic exp_pr, exp_cr, acc_p, acc_c;
        int   sz;
        @(negedge clk);
        push = p; pop = c; push_data = d;
        #1;
        sz     = mq.size();
        exp_pr = (busy == 0) && (sz < 8);
        exp_cr = (busy == 0) && (sz > 0) && !(p && sz < 8);
        check("push_ready", 32'(push_ready), 32'(exp_pr));
        check("pop_ready",  32'(pop_ready),  32'(exp_cr));
        check("count",      32'(count),      32'(sz));
        check("full",       32'(full),       32'(sz == 8));
        check("empty",      32'(empty),      32'(sz == 0));
        acc_p = p && exp_pr;
        acc_c = c && exp_cr;
        @(posedge clk);
        #1;
        if (acc_p) begin
            check("wr_ram_w",    32'(ram_w),     32'd1);
            check("wr_ram_r",    32'(ram_r),     32'd0);
            check("wr_addr",     32'(ram_addr),  32'(wr_idx));
            check("wr_data",     32'(ram_d),     32'(d));
            check("wr_pop_vld",  32'(pop_valid), 32'(busy == 2));
            mq.push_back(d);
            wr_idx = (wr_idx + 1) % 8;
            busy   = 1;
        end else if (acc_c) begin
            check("rd_ram_r",    32'(ram_r),     32'd1);
            check("rd_ram_w",    32'(ram_w),     32'd0);
            check("rd_addr",     32'(ram_addr),  32'(rd_idx));
            check("rd_pop_vld",  32'(pop_valid), 32'd0);
            pend   = mq.pop_front();
            rd_idx = (rd_idx + 1) % 8;
            busy   = 2;
        end else begin
            check("idle_ram_w",  32'(ram_w), 32'd0);
            check("idle_ram_r",  32'(ram_r), 32'd0);
            if (busy == 2) begin
                check("pop_valid", 32'(pop_valid), 32'd1);
                check("pop_data",  32'(pop_data),  32'(pend));
                last_pd = pend;
            end else begin
                check("no_pop_vld", 32'(pop_valid), 32'd0);
                check("pop_hold",   32'(pop_data),  32'(last_pd));
            end
            busy = 0;
        end
    endtask

    task automatic do_push(input logic [15:0] d);
        step(1'b1, 1'b0, d);
        step(1'b0, 1'b0, 16'h0);
    endtask

    task automatic do_pop();
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        push = 1'b0; pop = 1'b0; push_data = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty",  32'(empty),      32'd1);
        check("rst_full",   32'(full),       32'd0);
        check("rst_count",  32'(count),      32'd0);
        check("rst_pushrdy",32'(push_ready), 32'd1);
        check("rst_poprdy", 32'(pop_ready),  32'd0);
        check("rst_ram_w",  32'(ram_w),      32'd0);
        check("rst_ram_r",  32'(ram_r),      32'd0);
        check("rst_addr",   32'(ram_addr),   32'd0);
        check("rst_ram_d",  32'(ram_d),      32'd0);
        check("rst_pop_vld",32'(pop_valid),  32'd0);
        check("rst_pop_dat",32'(pop_data),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Fill to capacity, then one rejected push
        for (int i = 1; i <= 8; i++) do_push(16'(i * 16'h1111));
        check("fill_count", 32'(count), 32'd8);
        check("fill_full",  32'(full),  32'd1);
        step(1'b1, 1'b0, 16'hDEAD);
        step(1'b0, 1'b0, 16'h0);

        // Drain, then one rejected pop
        for (int i = 0; i < 8; i++) do_pop();
        check("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b0, 16'h0);

        // Pointer wrap: writes land at 5,6,7,0,1,2
        for (int i = 0; i < 5; i++) do_push(16'($urandom));
        for (int i = 0; i < 5; i++) do_pop();
        for (int i = 0; i < 6; i++) do_push(16'($urandom));
        for (int i = 0; i < 6; i++) do_pop();
        check("wrap_count", 32'(count), 32'd0);

        // Simultaneous push and pop: push wins unless full
        do_push(16'h0101);
        do_push(16'h0202);
        step(1'b1, 1'b1, 16'hAAAA);
        check("sim_cnt3", 32'(count), 32'd3);
        step(1'b0, 1'b1, 16'h0);
        step(1'b0, 1'b1, 16'h0);
        check("sim_cnt2", 32'(count), 32'd2);
        step(1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 6; i++) do_push(16'($urandom));
        step(1'b1, 1'b1, 16'hBBBB);
        check("sim_full_pop", 32'(count), 32'd7);
        step(1'b0, 1'b0, 16'h0);

        // Reset in the middle of a READ
        step(1'b0, 1'b1, 16'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_ram_r",  32'(ram_r), 32'd0);
        check("mid_count",  32'(count), 32'd0);
        check("mid_empty",  32'(empty), 32'd1);
        @(posedge clk);
        #1;
        check("mid_no_vld", 32'(pop_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(1'b0, 1'b1, 16'h0);

        // Random traffic
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
